mips_divider: RTL

Multi-cycle integer divider for the MIPS DIV/DIVU instructions, computing quotient (LO) and remainder (HI).
- Restoring division at one quotient bit per cycle; it is the subtract-direction counterpart of the datapath adders.
- Sits beside the ALU in EX; the pipeline control stalls on busy and captures results on done.

---
 rtl/mips_div_pkg.sv | 21 ++
 rtl/div_sub33.sv | 20 ++
 rtl/mips_divider.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mips_div_pkg.sv
// ============================================================================
// mips_div_pkg : shared constants and state encoding for the MIPS divider
// Revision     : 1.0
// ============================================================================
`default_nettype none

package mips_div_pkg;

   localparam int DIV_WIDTH   = 32;
   localparam int DIV_LATENCY = DIV_WIDTH + 2;

   typedef logic [1:0] state_t;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DIVIDE = 2'd1;
   localparam logic [1:0] S_FIXUP  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/div_sub33.sv
// ============================================================================
// div_sub33 : combinational N-bit subtractor, {borrow, diff} = a - b
// Revision  : 1.0
// ============================================================================
`default_nettype none

module div_sub33 #(
   parameter int N = 33
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);

   assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

`default_nettype wire

// File: rtl/mips_divider.sv
// ============================================================================
// mips_divider : multi-cycle restoring divider for MIPS DIV/DIVU (LO/HI)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mips_divider
   import mips_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  rem_q;
   logic [WIDTH-1:0]  quo_q;
   logic [WIDTH-1:0]  dsr_q;
   logic              a_neg;
   logic              b_neg;

   logic              w_a_neg;
   logic              w_b_neg;
   logic [WIDTH-1:0]  w_dvd_mag;
   logic [WIDTH-1:0]  w_dsr_mag;
   logic [WIDTH:0]    w_shift;
   logic [WIDTH:0]    w_trial;
   logic              w_borrow;
   logic              w_qbit;
   logic              w_accept;
   logic [WIDTH-1:0]  w_rem_fix;
   logic [WIDTH-1:0]  w_quo_fix;

   assign w_a_neg   = is_signed & dividend[WIDTH-1];
   assign w_b_neg   = is_signed & divisor[WIDTH-1];
   assign w_dvd_mag = w_a_neg ? -dividend : dividend;
   assign w_dsr_mag = w_b_neg ? -divisor  : divisor;
   assign w_accept  = start & ((state == S_IDLE) | (state == S_DONE));

   assign w_shift = {rem_q, quo_q[WIDTH-1]};

   div_sub33 #(
      .N (WIDTH + 1)
   ) u_sub (
      .a      (w_shift),
      .b      ({1'b0, dsr_q}),
      .diff   (w_trial),
      .borrow (w_borrow)
   );

   // The partial remainder stays below the divisor, so a non-borrowing trial
   // never sets its top bit; folding it in keeps the whole difference live.
   assign w_qbit = ~(w_borrow | w_trial[WIDTH]);

   // Magnitude results are re-signed here; a_neg is only ever set for DIV.
   assign w_rem_fix = a_neg ? -rem_q : rem_q;
   assign w_quo_fix = div_by_zero   ? {WIDTH{1'b1}} :
                      (a_neg ^ b_neg) ? -quo_q : quo_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dsr_q       <= '0;
         a_neg       <= 1'b0;
         b_neg       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (w_accept) begin
                  state       <= S_DIVIDE;
                  cnt         <= CW'(WIDTH - 1);
                  rem_q       <= '0;
                  quo_q       <= w_dvd_mag;
                  dsr_q       <= w_dsr_mag;
                  a_neg       <= w_a_neg;
                  b_neg       <= w_b_neg;
                  div_by_zero <= (divisor == '0);
                  busy        <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_DIVIDE: begin
               rem_q <= w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
               quo_q <= {quo_q[WIDTH-2:0], w_qbit};
               cnt   <= cnt - CW'(1);
               if (cnt == '0) begin
                  state <= S_FIXUP;
               end
            end
            S_FIXUP: begin
               state     <= S_DONE;
               busy      <= 1'b0;
               done      <= 1'b1;
               quotient  <= w_quo_fix;
               remainder <= w_rem_fix;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
